// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: runs decoded SPI frames (LED brightness WRITE/READ) and drives one PWM output per LED.
// Build macro SPI_CTRL_WR_ECHO_EN: a valid WRITE also arms an echo response frame.
module spi_led_ctrl #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_DIV  = 1250
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                i_rx_dv,
    input  logic [7:0]          i_cmd,
    input  logic [7:0]          i_addr,
    input  logic [7:0]          i_payload,
    output logic                o_slv_tx_enb,
    output logic [23:0]         o_slv_frame,
    output logic [NUM_LEDS-1:0] o_led,
    output logic [7:0]          o_err_cnt
);
    localparam logic [7:0]  CMD_NOP    = 8'h00;
    localparam logic [7:0]  CMD_WRITE  = 8'h01;
    localparam logic [7:0]  CMD_READ   = 8'h02;
    localparam int          AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int          PW         = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [8:0]  NUM_LEDS_W = 9'(NUM_LEDS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PWM_DIV - 1);
`ifdef SPI_CTRL_WR_ECHO_EN
    localparam bit WR_ECHO = 1'b1;
`else
    localparam bit WR_ECHO = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, ARM, TX} state_t;

    state_t          state, next_state;
    logic [7:0]      buf_cmd, buf_addr, buf_payload;
    logic            pend_valid;
    logic [7:0]      cur_cmd, cur_addr, cur_payload;
    logic [7:0]      duty   [NUM_LEDS];
    logic [7:0]      shadow [NUM_LEDS];
    logic [PW-1:0]   presc;
    logic [6:0]      step;
    logic            presc_wrap, period_wrap;
    logic            addr_ok, is_write, is_read, exec_err, resp;
    logic [AW-1:0]   idx;
    logic [7:0]      clamped;
    logic [23:0]     resp_frame;
    logic            ovw, exec_now;
    logic [8:0]      err_sum;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_rx_dv || pend_valid) next_state = DECODE;
            DECODE:  next_state = EXEC;
            EXEC:    next_state = resp ? ARM : IDLE;
            ARM:     if (!cs) next_state = TX;
            TX:      if (cs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Enable falls combinationally with cs in TX so spi_slave sees it drop the cycle cs returns high.
    always_comb begin
        o_slv_tx_enb = (state == ARM) || ((state == TX) && !cs);
    end

    always_comb begin
        addr_ok  = ({1'b0, cur_addr} < NUM_LEDS_W);
        idx      = cur_addr[AW-1:0];
        clamped  = (cur_payload > 8'd100) ? 8'd100 : cur_payload;
        is_write = (cur_cmd == CMD_WRITE);
        is_read  = (cur_cmd == CMD_READ);
        exec_err = (cur_cmd != CMD_NOP) && !((is_write || is_read) && addr_ok);
        resp     = exec_err || (is_read && addr_ok) || (WR_ECHO && is_write && addr_ok);
        resp_frame = {8'hFF, cur_addr, 8'h00};
        if (!exec_err && is_read)       resp_frame = {CMD_READ, cur_addr, duty[idx]};
        else if (!exec_err && is_write) resp_frame = {CMD_WRITE, cur_addr, clamped};
    end

    // Every pulse lands in the buffer; outside IDLE it is marked pending, and a pending overwrite is an error.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cmd     <= '0;
            buf_addr    <= '0;
            buf_payload <= '0;
            pend_valid  <= 1'b0;
        end else begin
            if (i_rx_dv) begin
                buf_cmd     <= i_cmd;
                buf_addr    <= i_addr;
                buf_payload <= i_payload;
            end
            if (i_rx_dv && (state != IDLE)) pend_valid <= 1'b1;
            else if (state == IDLE)         pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_cmd     <= '0;
            cur_addr    <= '0;
            cur_payload <= '0;
        end else if (state == DECODE) begin
            cur_cmd     <= buf_cmd;
            cur_addr    <= buf_addr;
            cur_payload <= buf_payload;
        end
    end

    always_comb begin
        ovw      = i_rx_dv && pend_valid;
        exec_now = (state == EXEC) && exec_err;
        err_sum  = {1'b0, o_err_cnt} + {8'd0, ovw} + {8'd0, exec_now};
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
            o_slv_frame <= '0;
            o_err_cnt   <= '0;
        end else begin
            o_err_cnt <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
            if (state == EXEC) begin
                if (resp) o_slv_frame <= resp_frame;
                for (int i = 0; i < NUM_LEDS; i++)
                    if (is_write && addr_ok && (idx == AW'(i))) duty[i] <= clamped;
            end
        end
    end

    // Shadow copies only at the period boundary so a new duty never cuts a PWM period short.
    always_comb begin
        presc_wrap  = (presc == PRESC_MAX);
        period_wrap = presc_wrap && (step == 7'd99);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            step  <= '0;
            for (int i = 0; i < NUM_LEDS; i++) shadow[i] <= '0;
        end else begin
            presc <= presc_wrap ? '0 : presc + PW'(1);
            if (presc_wrap) step <= (step == 7'd99) ? 7'd0 : step + 7'd1;
            if (period_wrap)
                for (int i = 0; i < NUM_LEDS; i++) shadow[i] <= duty[i];
        end
    end

    always_comb begin
        o_led = '0;
        for (int i = 0; i < NUM_LEDS; i++) o_led[i] = ({1'b0, step} < shadow[i]);
    end
endmodule

// File: tb/tb_spi_led_ctrl.sv
// tb_spi_led_ctrl: randomized and directed frames checked every cycle against a frame-level model.
// Honours SPI_CTRL_WR_ECHO_EN the same way the design does.
module tb_spi_led_ctrl;
    localparam int NUM_LEDS_TB = 4;
    localparam int PWM_DIV_TB  = 3;
    localparam int PERIOD      = 100 * PWM_DIV_TB;
    localparam int PH_READY = 0, PH_LATCH = 1, PH_APPLY = 2, PH_ARMED = 3, PH_SENDING = 4;

    logic                   sysclk    = 1'b0;
    logic                   rst_n     = 1'b1;
    logic                   cs        = 1'b1;
    logic                   i_rx_dv   = 1'b0;
    logic [7:0]             i_cmd     = '0;
    logic [7:0]             i_addr    = '0;
    logic [7:0]             i_payload = '0;
    logic                   o_slv_tx_enb;
    logic [23:0]            o_slv_frame;
    logic [NUM_LEDS_TB-1:0] o_led;
    logic [7:0]             o_err_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_on     = 1'b0;

    int          m_stage;
    int          m_cnt;
    logic [7:0]  m_duty   [NUM_LEDS_TB];
    logic [7:0]  m_shadow [NUM_LEDS_TB];
    logic [7:0]  m_err;
    logic [23:0] m_frame;
    bit          m_pend_full;
    logic [7:0]  m_pend_cmd, m_pend_addr, m_pend_pay;
    logic [7:0]  m_cur_cmd, m_cur_addr, m_cur_pay;

    spi_led_ctrl #(.NUM_LEDS(NUM_LEDS_TB), .PWM_DIV(PWM_DIV_TB)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .cs           (cs),
        .i_rx_dv      (i_rx_dv),
        .i_cmd        (i_cmd),
        .i_addr       (i_addr),
        .i_payload    (i_payload),
        .o_slv_tx_enb (o_slv_tx_enb),
        .o_slv_frame  (o_slv_frame),
        .o_led        (o_led),
        .o_err_cnt    (o_err_cnt)
    );

    always #4 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = PH_READY; m_cnt = 0; m_err = '0; m_frame = '0; m_pend_full = 1'b0;
        for (int i = 0; i < NUM_LEDS_TB; i++) begin m_duty[i] = '0; m_shadow[i] = '0; end
    endtask

    task automatic model_bump_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    task automatic model_exec();
        int  a  = int'(m_cur_addr);
        bit  ok = (a < NUM_LEDS_TB);
        bit  rsp = 1'b0;
        bit  bad = 1'b0;
        if (m_cur_cmd == 8'h01) begin
            if (ok) begin
                m_duty[a] = (m_cur_pay > 8'd100) ? 8'd100 : m_cur_pay;
`ifdef SPI_CTRL_WR_ECHO_EN
                m_frame = {8'h01, m_cur_addr, m_duty[a]};
                rsp = 1'b1;
`endif
            end else bad = 1'b1;
        end else if (m_cur_cmd == 8'h02) begin
            if (ok) begin m_frame = {8'h02, m_cur_addr, m_duty[a]}; rsp = 1'b1; end
            else bad = 1'b1;
        end else if (m_cur_cmd != 8'h00) bad = 1'b1;
        if (bad) begin model_bump_err(); m_frame = {8'hFF, m_cur_addr, 8'h00}; rsp = 1'b1; end
        m_stage = rsp ? PH_ARMED : PH_READY;
    endtask

    function automatic logic [NUM_LEDS_TB-1:0] exp_led();
        logic [NUM_LEDS_TB-1:0] v;
        int s = (m_cnt / PWM_DIV_TB) % 100;
        for (int i = 0; i < NUM_LEDS_TB; i++) v[i] = (s < int'(m_shadow[i]));
        return v;
    endfunction

    // Frame-level reference: a frame takes effect two cycles after its pulse, responses wait on cs.
    initial begin
        model_reset();
        forever begin
            @(posedge sysclk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                if ((m_cnt + 1) % PERIOD == 0)
                    for (int i = 0; i < NUM_LEDS_TB; i++) m_shadow[i] = m_duty[i];
                m_cnt++;
                if (m_stage == PH_READY) begin
                    if (i_rx_dv) begin
                        if (m_pend_full) model_bump_err();
                        m_cur_cmd = i_cmd; m_cur_addr = i_addr; m_cur_pay = i_payload;
                        m_pend_full = 1'b0; m_stage = PH_LATCH;
                    end else if (m_pend_full) begin
                        m_cur_cmd = m_pend_cmd; m_cur_addr = m_pend_addr; m_cur_pay = m_pend_pay;
                        m_pend_full = 1'b0; m_stage = PH_LATCH;
                    end
                end else begin
                    if (i_rx_dv) begin
                        if (m_pend_full) model_bump_err();
                        m_pend_cmd = i_cmd; m_pend_addr = i_addr; m_pend_pay = i_payload;
                        m_pend_full = 1'b1;
                    end
                    case (m_stage)
                        PH_LATCH:   m_stage = PH_APPLY;
                        PH_APPLY:   model_exec();
                        PH_ARMED:   if (!cs) m_stage = PH_SENDING;
                        PH_SENDING: if (cs) m_stage = PH_READY;
                        default:    m_stage = PH_READY;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (check_on) begin
                checkOutput("tx_enb", {31'd0, o_slv_tx_enb},
                            {31'd0, (m_stage == PH_ARMED) || ((m_stage == PH_SENDING) && !cs)});
                checkOutput("frame", {8'd0, o_slv_frame}, {8'd0, m_frame});
                checkOutput("err_cnt", {24'd0, o_err_cnt}, {24'd0, m_err});
                checkOutput("led", {28'd0, o_led}, {28'd0, exp_led()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] pay);
        i_cmd = cmd; i_addr = addr; i_payload = pay; i_rx_dv = 1'b1;
        tick(1);
        i_rx_dv = 1'b0;
    endtask

    task automatic waitStage(input int s);
        int n = 0;
        while (m_stage != s && n < 40) begin tick(1); n++; end
        checkOutput("wait stage bound", n, (n < 40) ? n : 0);
    endtask

    task automatic serveAll();
        int n = 0;
        while (!(m_stage == PH_READY && !m_pend_full) && n < 60) begin
            if (m_stage == PH_ARMED) cs = 1'b0;
            else if (m_stage == PH_SENDING) cs = 1'b1;
            tick(1); n++;
        end
        cs = 1'b1;
        tick(1);
        checkOutput("drain bound", {31'd0, n < 60}, 32'd1);
    endtask

    task automatic waitPhase(input int r);
        int n = 0;
        while ((m_cnt % PERIOD) != r && n < 2 * PERIOD) begin tick(1); n++; end
        checkOutput("period align bound", {31'd0, n < 2 * PERIOD}, 32'd1);
    endtask

    function automatic logic [7:0] rand_cmd();
        int r = $urandom_range(0, 9);
        if (r < 2) return 8'h00;
        if (r < 5) return 8'h01;
        if (r < 8) return 8'h02;
        return 8'($urandom);
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hi;
        int n;
        $display("[TB] start");
        #2 rst_n = 1'b0;
        tick(3);
        @(negedge sysclk);
        checkOutput("reset tx_enb", {31'd0, o_slv_tx_enb}, 32'd0);
        checkOutput("reset frame", {8'd0, o_slv_frame}, 32'd0);
        checkOutput("reset led", {28'd0, o_led}, 32'd0);
        checkOutput("reset err", {24'd0, o_err_cnt}, 32'd0);
        @(posedge sysclk); #1;
        rst_n = 1'b1;
        check_on = 1'b1;

        applyStimulus(8'h01, 8'h02, 8'h32);
        repeat (3) @(negedge sysclk);
`ifdef SPI_CTRL_WR_ECHO_EN
        checkOutput("write2 echo enb", {31'd0, o_slv_tx_enb}, 32'd1);
`else
        checkOutput("write2 no enb", {31'd0, o_slv_tx_enb}, 32'd0);
`endif
        tick(1);
        serveAll();
        waitPhase(0);
        hi = 0;
        repeat (PERIOD) begin @(negedge sysclk); if (o_led[2]) hi++; end
        checkOutput("led2 high cycles", hi, 50 * PWM_DIV_TB);
        tick(1);

        applyStimulus(8'h01, 8'h00, 8'hC8);
        serveAll();
        applyStimulus(8'h02, 8'h00, 8'h5A);
        @(negedge sysclk);
        checkOutput("read N+1 enb", {31'd0, o_slv_tx_enb}, 32'd0);
        @(negedge sysclk);
        checkOutput("read N+2 enb", {31'd0, o_slv_tx_enb}, 32'd0);
        @(negedge sysclk);
        checkOutput("read N+3 enb", {31'd0, o_slv_tx_enb}, 32'd1);
        checkOutput("read frame", {8'd0, o_slv_frame}, 32'h020064);
        @(posedge sysclk); #1;
        cs = 1'b0;
        repeat (3) begin
            @(negedge sysclk);
            checkOutput("cs low enb", {31'd0, o_slv_tx_enb}, 32'd1);
        end
        @(posedge sysclk); #1;
        cs = 1'b1;
        @(negedge sysclk);
        checkOutput("cs high enb", {31'd0, o_slv_tx_enb}, 32'd0);
        tick(1);
        serveAll();

        applyStimulus(8'h02, 8'h07, 8'h00);
        repeat (3) @(negedge sysclk);
        checkOutput("bad addr frame", {8'd0, o_slv_frame}, 32'hFF0700);
        checkOutput("bad addr err", {24'd0, o_err_cnt}, 32'd1);
        tick(1);
        serveAll();
        applyStimulus(8'h05, 8'h00, 8'h00);
        repeat (3) @(negedge sysclk);
        checkOutput("bad cmd err", {24'd0, o_err_cnt}, 32'd2);
        tick(1);
        serveAll();

        applyStimulus(8'h02, 8'h02, 8'h00);
        waitStage(PH_ARMED);
        checkOutput("read2 frame", {8'd0, o_slv_frame}, 32'h020232);
        cs = 1'b0;
        tick(2);
        applyStimulus(8'h01, 8'h01, 8'h0A);
        cs = 1'b1;
        tick(1);
        serveAll();
        applyStimulus(8'h02, 8'h01, 8'h00);
        repeat (3) @(negedge sysclk);
        checkOutput("b2b duty1 frame", {8'd0, o_slv_frame}, 32'h02010A);
        tick(1);
        serveAll();
        applyStimulus(8'h02, 8'h03, 8'h00);
        waitStage(PH_ARMED);
        cs = 1'b0;
        tick(1);
        cs = 1'b1;
        applyStimulus(8'h01, 8'h00, 8'h05);
        serveAll();
        applyStimulus(8'h02, 8'h00, 8'h00);
        repeat (3) @(negedge sysclk);
        checkOutput("same-cycle duty0 frame", {8'd0, o_slv_frame}, 32'h020005);
        tick(1);
        serveAll();

        applyStimulus(8'h01, 8'h03, 8'hFF);
        repeat (3) @(negedge sysclk);
`ifdef SPI_CTRL_WR_ECHO_EN
        checkOutput("echo frame", {8'd0, o_slv_frame}, 32'h010364);
        checkOutput("echo enb", {31'd0, o_slv_tx_enb}, 32'd1);
`else
        checkOutput("no echo enb", {31'd0, o_slv_tx_enb}, 32'd0);
`endif
        tick(1);
        serveAll();

        for (int k = 0; k < 260; k++) begin
            applyStimulus(8'hA5, 8'h00, 8'h00);
            serveAll();
        end
        checkOutput("err saturate", {24'd0, o_err_cnt}, 32'd255);

        waitPhase(1);
        @(negedge sysclk);
        checkOutput("led3 full on", {31'd0, o_led[3]}, 32'd1);
        tick(1);
        applyStimulus(8'h02, 8'h03, 8'h00);
        tick(2);
        #2;
        checkOutput("arm enb before reset", {31'd0, o_slv_tx_enb}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset enb", {31'd0, o_slv_tx_enb}, 32'd0);
        checkOutput("async reset frame", {8'd0, o_slv_frame}, 32'd0);
        checkOutput("async reset err", {24'd0, o_err_cnt}, 32'd0);
        checkOutput("async reset led", {28'd0, o_led}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        @(negedge sysclk);
        checkOutput("led3 after reset", {31'd0, o_led[3]}, 32'd0);
        tick(1);

        for (int t = 0; t < 150; t++) begin
            applyStimulus(rand_cmd(), 8'($urandom_range(0, 5)), 8'($urandom));
            for (int k = 0; k < $urandom_range(0, 3); k++) begin
                if ($urandom_range(0, 2) == 0)
                    applyStimulus(rand_cmd(), 8'($urandom_range(0, 5)), 8'($urandom));
                else
                    tick(1);
            end
            n = 0;
            while (!(m_stage == PH_READY && !m_pend_full) && n < 80) begin
                i_rx_dv = 1'b0;
                if (m_stage == PH_ARMED && $urandom_range(0, 1) == 0) cs = 1'b0;
                else if (m_stage == PH_SENDING && !cs && $urandom_range(0, 2) == 0) cs = 1'b1;
                if (m_stage == PH_SENDING && $urandom_range(0, 3) == 0) begin
                    i_cmd = rand_cmd(); i_addr = 8'($urandom_range(0, 5));
                    i_payload = 8'($urandom); i_rx_dv = 1'b1;
                end
                tick(1); n++;
            end
            i_rx_dv = 1'b0;
            cs = 1'b1;
            checkOutput("random drain bound", {31'd0, n < 80}, 32'd1);
            serveAll();
        end

        check_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/spi_led_ctrl.md
# spi_led_ctrl

Command controller between `spi_slave` and the board LEDs. It consumes each decoded SPI frame (cmd/addr/payload plus a valid pulse) and executes it: WRITE sets a per-LED brightness in percent, READ arms a response frame that `spi_slave` shifts out on MISO during the next chip-select transaction. It also generates one PWM output per LED from the stored brightness values.

## Interface
Parameters:
- `NUM_LEDS`, 4: number of LED channels; the address range is 0..NUM_LEDS-1.
- `PWM_DIV`, 1250: sysclk cycles per PWM step. At 125 MHz this gives a 100 kHz step and a 1 kHz PWM period of 100 steps.

Ports:
- `sysclk` in 1: the single clock, 125 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `cs` in 1: SPI chip select, active low (`CS_ASSERT`=0), already synchronous to sysclk.
- `i_rx_dv` in 1: one-cycle pulse; the frame on `i_cmd`/`i_addr`/`i_payload` is valid.
- `i_cmd` in 8: command byte. Values: `CMD_NOP`=8'h00, `CMD_WRITE`=8'h01, `CMD_READ`=8'h02.
- `i_addr` in 8: LED index.
- `i_payload` in 8: brightness in percent.
- `o_slv_tx_enb` out 1: drives `slv_tx_enb` of `spi_slave`.
- `o_slv_frame` out 24: drives `i_slv_frame` of `spi_slave`.
- `o_led` out NUM_LEDS: PWM outputs.
- `o_err_cnt` out 8: count of rejected frames; saturates at 255.

## Operation
- FSM states:
  - IDLE: waits for `i_rx_dv`.
  - DECODE: latches cmd/addr/payload.
  - EXEC: applies the command.
  - ARM: `o_slv_tx_enb`=1; waits for `cs`=0.
  - TX: `o_slv_tx_enb`=1; waits for `cs`=1.
- IDLE→DECODE on `i_rx_dv`. DECODE→EXEC always.
- EXEC→ARM if the command produced a response frame, else EXEC→IDLE. ARM→TX on `cs`=0. TX→IDLE on `cs`=1; `o_slv_tx_enb` drops in the same cycle.
- WRITE with a valid address:
  - `duty[addr]` = min(payload, 100).
  - Payloads 101..255 clamp to 100.
- READ with a valid address: `o_slv_frame` = {8'h02, addr, duty[addr]}.
- Invalid command or address ≥ NUM_LEDS:
  - `o_err_cnt` increments.
  - `o_slv_frame` = {8'hFF, addr, 8'h00}, response armed.
  - No duty register changes.
- NOP: no action, no error, no response.
- A pulse on `i_rx_dv` outside IDLE is held in a one-deep pending register and consumed on the next return to IDLE. This is the normal case: the frame clocked in during TX arrives while in TX.
  - A second pulse while pending is full overwrites it (last frame wins).
  - An overwrite also increments `o_err_cnt`.
- `o_slv_frame` is held stable from EXEC until leaving TX.
- PWM:
  - A prescaler counts 0..PWM_DIV-1; `step` counts 0..99 on each prescaler wrap.
  - `o_led[i]` = (step < shadow_duty[i]).
  - `shadow_duty` loads from `duty` only when `step` wraps 99→0, so there are no glitches mid-period.
  - duty 0 gives constant low; duty 100 gives constant high.

## Timing
- Reset values:
  - FSM = IDLE; `o_slv_tx_enb`=0; `o_slv_frame`=0.
  - `o_led`=0; `o_err_cnt`=0.
  - All duty and shadow registers = 0; pending register empty; prescaler and step = 0.
- Frame-to-effect latency: `i_rx_dv` in cycle N; DECODE in N+1; EXEC in N+2.
  - The duty register, `o_err_cnt` and `o_slv_frame` update at the end of N+2.
  - `o_slv_tx_enb`=1 from N+3.
- A WRITE reaches `o_led` at the next PWM period boundary, at most 100×PWM_DIV cycles later.
- `cs` rising edge while in ARM: ignored; stay in ARM (response not yet sent).
- `rst_n` asserted mid-transaction:
  - Immediate return to reset values.
  - `o_slv_tx_enb` drops asynchronously, and the pending frame is discarded.
- `i_rx_dv` and `cs`=1 arriving in the same TX cycle: the frame goes to pending and the FSM goes to IDLE. It enters DECODE the following cycle.

## Configuration
- `SPI_CTRL_WR_ECHO_EN`:
  - Defined: a valid WRITE also arms a response frame {8'h01, addr, clamped duty}, and the FSM goes EXEC→ARM.
  - Undefined: a valid WRITE produces no response, and `o_slv_tx_enb` stays 0 (EXEC→IDLE).
  - Error and READ behaviour is identical in both builds.

## Test plan
- Reset, then WRITE {01,02,32}:
  - `duty[2]`=50.
  - After the next period boundary `o_led[2]` is high for 50×PWM_DIV cycles per 100×PWM_DIV.
  - `o_slv_tx_enb`=0 without the echo macro.
- WRITE {01,00,C8}, then READ {02,00,xx}:
  - `o_slv_frame`=24'h020064, `o_slv_tx_enb`=1 from N+3.
  - Stays 1 through the cs-low window; drops the cycle `cs` returns high.
- READ {02,07,00} with NUM_LEDS=4:
  - `o_slv_frame`=24'hFF0700, `o_err_cnt`=1, no duty changed.
  - Command 8'h05 also gives `o_err_cnt`=2.
- Back-to-back: READ armed; during TX a new WRITE {01,01,0A} arrives on `i_rx_dv`.
  - After `cs` rises: IDLE then DECODE next cycle; `duty[1]`=10.
- `rst_n` pulsed low while in ARM with `duty[3]`=100:
  - All outputs return to reset values, `o_slv_tx_enb`=0 immediately.
  - `o_led[3]`=0 after release.
- With `SPI_CTRL_WR_ECHO_EN` defined, WRITE {01,03,FF}:
  - `o_slv_frame`=24'h010364, `o_slv_tx_enb`=1 until the next cs-high.
